// File: rtl/map_redraw_ctrl_pkg.sv
// Shared game parameters: map grid defaults and redraw FSM state encoding.
package game_params;

  localparam int MAP_WIDTH_DEF  = 13;
  localparam int MAP_HEIGHT_DEF = 13;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

endpackage

// File: rtl/map_redraw_ctrl_scan.sv
// Row-major grid scan counter: x is the inner index, y the outer one.
module grid_scan_cnt
  import game_params::*;
#(
  parameter int WIDTH  = MAP_WIDTH_DEF,
  parameter int HEIGHT = MAP_HEIGHT_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clear,
  input  logic       step,
  output logic [3:0] cnt_x,
  output logic [3:0] cnt_y,
  output logic       last
);

  logic [3:0] r_x;
  logic [3:0] r_y;
  logic       w_x_end;
  logic       w_y_end;

  assign w_x_end = (r_x == 4'(WIDTH - 1));
  assign w_y_end = (r_y == 4'(HEIGHT - 1));
  assign cnt_x   = r_x;
  assign cnt_y   = r_y;
  assign last    = w_x_end && w_y_end;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_x <= 4'd0;
      r_y <= 4'd0;
    end else if (clear) begin
      r_x <= 4'd0;
      r_y <= 4'd0;
    end else if (step) begin
      if (w_x_end) begin
        r_x <= 4'd0;
        r_y <= w_y_end ? 4'd0 : r_y + 4'd1;
      end else begin
        r_x <= r_x + 4'd1;
      end
    end
  end

endmodule

// File: rtl/map_redraw_ctrl.sv
// Map redraw sequencer: issues tile-render requests for full or dirty-cell redraws.
// Define MAP_REDRAW_DIRTY_EN to redraw only the old and new hero cells on a move.
module map_redraw_ctrl
  import game_params::*;
#(
  parameter int MAP_WIDTH  = MAP_WIDTH_DEF,
  parameter int MAP_HEIGHT = MAP_HEIGHT_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [18:0] map_id,
  input  logic [3:0]  player_x,
  input  logic [3:0]  player_y,
  input  logic        full_redraw_req,
  output logic [3:0]  cell_x,
  output logic [3:0]  cell_y,
  output logic [18:0] cell_map_id,
  output logic [3:0]  hero_x,
  output logic [3:0]  hero_y,
  output logic        cell_start,
  input  logic        cell_done,
  output logic        busy,
  output logic        frame_done
);

  logic [1:0]  r_state;
  logic [18:0] r_drawn_map;
  logic [3:0]  r_drawn_x;
  logic [3:0]  r_drawn_y;
  logic        r_full_pending;
  logic        r_busy;
  logic        r_frame_done;
  logic [18:0] r_cell_map_id;
  logic [3:0]  r_hero_x;
  logic [3:0]  r_hero_y;

  logic        w_pos_change;
  logic        w_trig_full;
  logic        w_go;
  logic        w_is_full;
  logic        w_last;
  logic        w_step;
  logic [3:0]  w_cnt_x;
  logic [3:0]  w_cnt_y;
  logic        w_cnt_last;

  assign w_pos_change = (player_x != r_drawn_x) || (player_y != r_drawn_y);

`ifdef MAP_REDRAW_DIRTY_EN
  logic       r_mode_full;
  logic       r_phase;
  logic [3:0] r_dirty_x;
  logic [3:0] r_dirty_y;

  assign w_trig_full = r_full_pending || full_redraw_req || (map_id != r_drawn_map);
  assign w_go        = (r_state == ST_IDLE) && (w_trig_full || w_pos_change);
  assign w_is_full   = r_mode_full;
  assign w_last      = r_mode_full ? w_cnt_last : r_phase;
  assign cell_x      = r_mode_full ? w_cnt_x : r_dirty_x;
  assign cell_y      = r_mode_full ? w_cnt_y : r_dirty_y;

  // Dirty redraw visits the previously drawn hero cell first, then the new one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mode_full <= 1'b1;
      r_phase     <= 1'b0;
      r_dirty_x   <= 4'd0;
      r_dirty_y   <= 4'd0;
    end else if (w_go) begin
      r_mode_full <= w_trig_full;
      r_phase     <= 1'b0;
      r_dirty_x   <= r_drawn_x;
      r_dirty_y   <= r_drawn_y;
    end else if ((r_state == ST_WAIT) && cell_done && !r_mode_full && !r_phase) begin
      r_phase     <= 1'b1;
      r_dirty_x   <= r_hero_x;
      r_dirty_y   <= r_hero_y;
    end
  end
`else
  assign w_trig_full = r_full_pending || full_redraw_req || (map_id != r_drawn_map) || w_pos_change;
  assign w_go        = (r_state == ST_IDLE) && w_trig_full;
  assign w_is_full   = 1'b1;
  assign w_last      = w_cnt_last;
  assign cell_x      = w_cnt_x;
  assign cell_y      = w_cnt_y;
`endif

  assign w_step = (r_state == ST_WAIT) && cell_done && w_is_full && !w_cnt_last;

  grid_scan_cnt #(
    .WIDTH  (MAP_WIDTH),
    .HEIGHT (MAP_HEIGHT)
  ) u_scan (
    .clk   (clk),
    .rstn  (rstn),
    .clear (w_go),
    .step  (w_step),
    .cnt_x (w_cnt_x),
    .cnt_y (w_cnt_y),
    .last  (w_cnt_last)
  );

  assign cell_start  = (r_state == ST_ISSUE);
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign cell_map_id = r_cell_map_id;
  assign hero_x      = r_hero_x;
  assign hero_y      = r_hero_y;

  // Snapshots are taken only when leaving IDLE, so inputs moving mid-redraw wait their turn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= ST_IDLE;
      r_drawn_map    <= 19'd0;
      r_drawn_x      <= 4'd0;
      r_drawn_y      <= 4'd0;
      r_full_pending <= 1'b1;
      r_busy         <= 1'b0;
      r_frame_done   <= 1'b0;
      r_cell_map_id  <= 19'd0;
      r_hero_x       <= 4'd0;
      r_hero_y       <= 4'd0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            r_state        <= ST_ISSUE;
            r_busy         <= 1'b1;
            r_full_pending <= 1'b0;
            r_cell_map_id  <= map_id;
            r_hero_x       <= player_x;
            r_hero_y       <= player_y;
            r_drawn_map    <= map_id;
            r_drawn_x      <= player_x;
            r_drawn_y      <= player_y;
          end
        end
        ST_ISSUE: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (cell_done) begin
            if (w_last) begin
              r_state      <= ST_IDLE;
              r_busy       <= 1'b0;
              r_frame_done <= 1'b1;
            end else begin
              r_state <= ST_ISSUE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (full_redraw_req && (r_state != ST_IDLE)) r_full_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_map_redraw_ctrl.sv
// Self-checking bench for map_redraw_ctrl: a renderer model answers each cell_start
// two cycles later while a scoreboard queue holds the cells each redraw must visit.
module tb_map_redraw_ctrl;

  typedef struct packed {
    logic [3:0]  x;
    logic [3:0]  y;
    logic [18:0] m;
    logic [3:0]  hx;
    logic [3:0]  hy;
  } cell_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [18:0] map_id = 19'd0;
  logic [3:0]  player_x = 4'd0;
  logic [3:0]  player_y = 4'd0;
  logic        full_redraw_req = 1'b0;
  logic [3:0]  cell_x, cell_y, hero_x, hero_y;
  logic [18:0] cell_map_id;
  logic        cell_start, busy, frame_done;
  logic        cell_done;
  logic        respDone = 1'b0;
  logic        spuriousDone = 1'b0;

  cell_t q[$];
  cell_t curr;
  int    checks = 0;
  int    errors = 0;
  int    startCount = 0;
  int    frameCount = 0;
  int    delay = 0;
  logic  waiting = 1'b0;

  assign cell_done = respDone | spuriousDone;

  map_redraw_ctrl dut (
    .clk             (clk),
    .rstn            (rstn),
    .map_id          (map_id),
    .player_x        (player_x),
    .player_y        (player_y),
    .full_redraw_req (full_redraw_req),
    .cell_x          (cell_x),
    .cell_y          (cell_y),
    .cell_map_id     (cell_map_id),
    .hero_x          (hero_x),
    .hero_y          (hero_y),
    .cell_start      (cell_start),
    .cell_done       (cell_done),
    .busy            (busy),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pushFrame(input logic [18:0] m, input logic [3:0] hx, input logic [3:0] hy);
    cell_t c;
    for (int y = 0; y < 13; y++) begin
      for (int x = 0; x < 13; x++) begin
        c = '{x: 4'(x), y: 4'(y), m: m, hx: hx, hy: hy};
        q.push_back(c);
      end
    end
  endtask

  // Expected cells for a hero move: two dirty cells or a full frame, by build.
  task automatic pushMove(input logic [18:0] m, input logic [3:0] ox, input logic [3:0] oy,
                          input logic [3:0] nx, input logic [3:0] ny);
`ifdef MAP_REDRAW_DIRTY_EN
    cell_t c;
    c = '{x: ox, y: oy, m: m, hx: nx, hy: ny};
    q.push_back(c);
    c = '{x: nx, y: ny, m: m, hx: nx, hy: ny};
    q.push_back(c);
`else
    pushFrame(m, nx, ny);
`endif
  endtask

  task automatic waitFrames(input int target);
    for (int i = 0; i < 4000 && frameCount < target; i++) tick();
    check("frame_wait", 64'(frameCount >= target), 64'd1);
  endtask

  task automatic waitStarts(input int target);
    for (int i = 0; i < 4000 && startCount < target; i++) tick();
    check("start_wait", 64'(startCount >= target), 64'd1);
  endtask

  task automatic checkResetOutputs();
    check("rst_cell_xy", {cell_x, cell_y}, 8'd0);
    check("rst_hero_xy", {hero_x, hero_y}, 8'd0);
    check("rst_map", cell_map_id, 19'd0);
    check("rst_start", cell_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
  endtask

  task automatic pulseReq();
    full_redraw_req = 1'b1;
    tick();
    full_redraw_req = 1'b0;
  endtask

  // Renderer model and scoreboard consumer, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rstn) begin
      respDone = 1'b0;
      waiting  = 1'b0;
      delay    = 0;
    end else begin
      if (respDone) begin
        respDone = 1'b0;
        check("done_latency", 64'(cell_start || frame_done), 64'd1);
      end
      if (frame_done) begin
        frameCount++;
        check("busy_at_frame_done", busy, 1'b0);
      end
      if (cell_start) begin
        startCount++;
        check("start_with_queue", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          cell_t e;
          e = q.pop_front();
          curr = '{x: cell_x, y: cell_y, m: cell_map_id, hx: hero_x, hy: hero_y};
          check("cell", 64'(curr), 64'(e));
          check("busy_in_redraw", busy, 1'b1);
        end
        waiting = 1'b1;
        delay   = 2;
      end else if (waiting) begin
        check("stable", 64'({cell_x, cell_y, cell_map_id, hero_x, hero_y}), 64'(curr));
        delay--;
        if (delay == 0) begin
          respDone = 1'b1;
          waiting  = 1'b0;
        end
      end
    end
  end

  initial begin
    int base;
    int f0;
    $display("[TB] start");
    repeat (3) tick();
    checkResetOutputs();

    pushFrame(19'd0, 4'd0, 4'd0);
    rstn = 1'b1;
    waitFrames(1);
    check("reset_frame_starts", startCount, 169);
    check("queue_after_reset_frame", q.size(), 0);

    tick();
    base = startCount;
    spuriousDone = 1'b1;
    tick();
    spuriousDone = 1'b0;
    repeat (4) tick();
    check("spurious_done_starts", startCount, base);
    check("spurious_done_busy", busy, 1'b0);

    pushMove(19'd0, 4'd0, 4'd0, 4'd3, 4'd4);
    player_x = 4'd3;
    player_y = 4'd4;
    waitFrames(2);
    base = startCount;
    pushMove(19'd0, 4'd3, 4'd4, 4'd3, 4'd5);
    player_y = 4'd5;
    waitFrames(3);
`ifdef MAP_REDRAW_DIRTY_EN
    check("dirty_pulses", startCount - base, 2);
`else
    check("move_full_pulses", startCount - base, 169);
`endif
    check("hero_after_move", {hero_x, hero_y}, {4'd3, 4'd5});
    check("queue_after_move", q.size(), 0);

    base = startCount;
    f0 = frameCount;
    pushFrame(19'd0, 4'd3, 4'd5);
    pulseReq();
    waitStarts(base + 50);
    pushFrame(19'd0, 4'd3, 4'd5);
    pulseReq();
    waitFrames(f0 + 2);
    check("req_while_busy_pulses", startCount - base, 338);
    check("queue_after_req", q.size(), 0);

    f0 = frameCount;
    base = startCount;
    pushMove(19'd0, 4'd3, 4'd5, 4'd7, 4'd8);
    player_x = 4'd7;
    player_y = 4'd8;
    waitStarts(base + 1);
    map_id = 19'd1;
    pushFrame(19'd1, 4'd7, 4'd8);
    waitFrames(f0 + 2);
    check("map_change_map", cell_map_id, 19'd1);
    check("queue_after_map_change", q.size(), 0);

    base = startCount;
    pushFrame(19'd1, 4'd7, 4'd8);
    pulseReq();
    waitStarts(base + 20);
    check("busy_before_reset", busy, 1'b1);
    rstn = 1'b0;
    q.delete();
    tick();
    checkResetOutputs();
    f0 = frameCount;
    pushFrame(19'd1, 4'd7, 4'd8);
    tick();
    rstn = 1'b1;
    waitFrames(f0 + 1);
    check("post_reset_map", cell_map_id, 19'd1);
    check("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
